// File: rtl/multicycle_control.sv
// -----------------------------------------------------------------------------
// multicycle_control
//
// Purpose:
//   Moore control FSM for a shared multicycle RV32I datapath (one ALU, one
//   memory, IR, A/B, ALUOut). Each instruction steps through FETCH, DECODE and
//   then a class-specific sequence, with one datapath step per cycle. Memory
//   states wait on iMEM_READY. If a memory wait lasts MEM_TIMEOUT cycles, the
//   FSM traps into a sticky ERROR state. An illegal opcode also traps there.
//
// Parameters:
//   MEM_TIMEOUT   maximum cycles with iMEM_READY low in a wait state
//                 (0 disables the timeout)
//
// Optional feature (macro CTRL_PERF_EN):
//   Adds the free-running counters oCYCLES and oINSTRET.
//
// Ports:
//   iCLK, iRST_N       clock and synchronous active-low reset
//   iOPCODE[6:0]       IR[6:0]; sampled in DECODE and MEMADR
//   iMEM_READY         memory completes the access this cycle
//   oMEM_REQ, oIorD, oMemRead, oMemWrite
//                      memory request, address select and direction
//   oIRWrite, oPCWrite, oPCWriteCond, oPCSource[1:0]
//                      IR and PC update controls
//   oRegWrite, oMemtoReg[1:0]
//                      register file write-back controls
//   oALUSrcA[1:0], oALUSrcB[1:0], oALUOp[1:0]
//                      ALU operand and operation selects
//   oSTATE[3:0]        current state encoding
//   oERROR             sticky error flag (illegal opcode or memory timeout)
//   oCYCLES, oINSTRET  performance counters (only with CTRL_PERF_EN)
// -----------------------------------------------------------------------------
module multicycle_control #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic        iCLK,
  input  logic        iRST_N,
  input  logic [6:0]  iOPCODE,
  input  logic        iMEM_READY,
  output logic        oMEM_REQ,
  output logic        oIorD,
  output logic        oMemRead,
  output logic        oMemWrite,
  output logic        oIRWrite,
  output logic        oPCWrite,
  output logic        oPCWriteCond,
  output logic [1:0]  oPCSource,
  output logic        oRegWrite,
  output logic [1:0]  oMemtoReg,
  output logic [1:0]  oALUSrcA,
  output logic [1:0]  oALUSrcB,
  output logic [1:0]  oALUOp,
  output logic [3:0]  oSTATE,
`ifdef CTRL_PERF_EN
  output logic [31:0] oCYCLES,
  output logic [31:0] oINSTRET,
`endif
  output logic        oERROR
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC_R = 4'd6,
    S_EXEC_I = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_JAL    = 4'd10,
    S_JALR   = 4'd11,
    S_ERROR  = 4'd15
  } state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  // The counter only has to reach MEM_TIMEOUT-1.
  localparam int              CW    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CW-1:0]   LIMIT = CW'(MEM_TIMEOUT - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;

  // ---------------------------------------------------------------------------
  // State and wait-counter registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      state_q    <= S_FETCH;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic. The wait counter defaults to zero, so it clears whenever
  // a memory state is left or any other state is active.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = '0;
    case (state_q)
      S_FETCH, S_MEMRD, S_MEMWR: begin
        if (iMEM_READY) begin
          // A ready arriving on the limit cycle still completes the access.
          case (state_q)
            S_FETCH: state_d = S_DECODE;
            S_MEMRD: state_d = S_MEMWB;
            default: state_d = S_FETCH;
          endcase
        end else if ((MEM_TIMEOUT != 0) && (wait_cnt_q == LIMIT)) begin
          state_d = S_ERROR;
        end else if (MEM_TIMEOUT != 0) begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      S_DECODE: begin
        case (iOPCODE)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXEC_R;
          OP_ITYPE:          state_d = S_EXEC_I;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR;
          default:           state_d = S_ERROR;
        endcase
      end
      S_MEMADR: state_d = (iOPCODE == OP_LOAD) ? S_MEMRD : S_MEMWR;
      S_MEMWB, S_ALUWB, S_BRANCH, S_JAL, S_JALR: state_d = S_FETCH;
      S_EXEC_R, S_EXEC_I: state_d = S_ALUWB;
      S_ERROR:  state_d = S_ERROR;
      default:  state_d = S_ERROR;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Moore outputs. FETCH gates IRWrite/PCWrite with ready so that the IR and PC
  // update only once, on the cycle in which the fetch completes. While reset is
  // asserted, every output is forced low. This also drops a request that is in
  // flight.
  // ---------------------------------------------------------------------------
  always_comb begin
    oMEM_REQ     = 1'b0;
    oIorD        = 1'b0;
    oMemRead     = 1'b0;
    oMemWrite    = 1'b0;
    oIRWrite     = 1'b0;
    oPCWrite     = 1'b0;
    oPCWriteCond = 1'b0;
    oPCSource    = 2'd0;
    oRegWrite    = 1'b0;
    oMemtoReg    = 2'd0;
    oALUSrcA     = 2'd0;
    oALUSrcB     = 2'd0;
    oALUOp       = 2'b00;
    oERROR       = 1'b0;
    oSTATE       = state_q;
    case (state_q)
      S_FETCH: begin
        oMEM_REQ = 1'b1;
        oMemRead = 1'b1;
        oALUSrcB = 2'd1;
        oIRWrite = iMEM_READY;
        oPCWrite = iMEM_READY;
      end
      S_DECODE: begin
        oALUSrcA = 2'd2;
        oALUSrcB = 2'd2;
      end
      S_MEMADR: begin
        oALUSrcA = 2'd1;
        oALUSrcB = 2'd2;
      end
      S_MEMRD: begin
        oMEM_REQ = 1'b1;
        oMemRead = 1'b1;
        oIorD    = 1'b1;
      end
      S_MEMWB: begin
        oRegWrite = 1'b1;
        oMemtoReg = 2'd1;
      end
      S_MEMWR: begin
        oMEM_REQ  = 1'b1;
        oMemWrite = 1'b1;
        oIorD     = 1'b1;
      end
      S_EXEC_R: begin
        oALUSrcA = 2'd1;
        oALUOp   = 2'b10;
      end
      S_EXEC_I: begin
        oALUSrcA = 2'd1;
        oALUSrcB = 2'd2;
        oALUOp   = 2'b11;
      end
      S_ALUWB: oRegWrite = 1'b1;
      S_BRANCH: begin
        oALUSrcA     = 2'd1;
        oALUOp       = 2'b01;
        oPCWriteCond = 1'b1;
        oPCSource    = 2'd1;
      end
      S_JAL: begin
        oPCWrite  = 1'b1;
        oPCSource = 2'd1;
        oRegWrite = 1'b1;
        oMemtoReg = 2'd2;
      end
      S_JALR: begin
        oALUSrcA  = 2'd1;
        oALUSrcB  = 2'd2;
        oPCWrite  = 1'b1;
        oPCSource = 2'd2;
        oRegWrite = 1'b1;
        oMemtoReg = 2'd2;
      end
      S_ERROR: oERROR = 1'b1;
      default: oERROR = 1'b1;
    endcase
    if (!iRST_N) begin
      oMEM_REQ     = 1'b0;
      oIorD        = 1'b0;
      oMemRead     = 1'b0;
      oMemWrite    = 1'b0;
      oIRWrite     = 1'b0;
      oPCWrite     = 1'b0;
      oPCWriteCond = 1'b0;
      oPCSource    = 2'd0;
      oRegWrite    = 1'b0;
      oMemtoReg    = 2'd0;
      oALUSrcA     = 2'd0;
      oALUSrcB     = 2'd0;
      oALUOp       = 2'b00;
      oERROR       = 1'b0;
      oSTATE       = 4'd0;
    end
  end

`ifdef CTRL_PERF_EN
  // ---------------------------------------------------------------------------
  // Performance counters. An instruction retires when the FSM re-enters FETCH
  // from any other state. Both counters wrap naturally.
  // ---------------------------------------------------------------------------
  logic [31:0] cycles_q, instret_q;

  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      cycles_q  <= '0;
      instret_q <= '0;
    end else begin
      cycles_q <= cycles_q + 32'd1;
      if ((state_q != S_FETCH) && (state_d == S_FETCH)) begin
        instret_q <= instret_q + 32'd1;
      end
    end
  end

  assign oCYCLES  = iRST_N ? cycles_q  : 32'd0;
  assign oINSTRET = iRST_N ? instret_q : 32'd0;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// -----------------------------------------------------------------------------
// tb_multicycle_control
//
// Purpose:
//   Scoreboard bench for multicycle_control. Each stimulus cycle drives the
//   inputs and queues the expected outputs for that cycle. A monitor on the
//   falling edge pops the queue and compares the result against the DUT.
//   Expected control words come from a table of per-state control values.
//
// Ports: none (top-level bench).
// Optional: CTRL_PERF_EN enables the performance counter checks.
// -----------------------------------------------------------------------------
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  opcode;
  logic        ready;
  logic        mem_req, iord, mem_read, mem_write, ir_write, pc_write, pc_wcond;
  logic [1:0]  pc_src, mem_to_reg, src_a, src_b, alu_op;
  logic        reg_write, error;
  logic [3:0]  state;
`ifdef CTRL_PERF_EN
  logic [31:0] cycles, instret;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  multicycle_control #(.MEM_TIMEOUT(16)) dut (
    .iCLK         (clk),
    .iRST_N       (rst_n),
    .iOPCODE      (opcode),
    .iMEM_READY   (ready),
    .oMEM_REQ     (mem_req),
    .oIorD        (iord),
    .oMemRead     (mem_read),
    .oMemWrite    (mem_write),
    .oIRWrite     (ir_write),
    .oPCWrite     (pc_write),
    .oPCWriteCond (pc_wcond),
    .oPCSource    (pc_src),
    .oRegWrite    (reg_write),
    .oMemtoReg    (mem_to_reg),
    .oALUSrcA     (src_a),
    .oALUSrcB     (src_b),
    .oALUOp       (alu_op),
    .oSTATE       (state),
`ifdef CTRL_PERF_EN
    .oCYCLES      (cycles),
    .oINSTRET     (instret),
`endif
    .oERROR       (error)
  );

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BAD    = 7'b1111111;

  // Control word layout:
  // state[4] err req iord mr mw irw pcw pcwc pcs[2] rw m2r[2] sa[2] sb[2] op[2]
  typedef logic [22:0] ctl_t;

  typedef struct {
    string name;
    ctl_t  exp;
  } exp_t;

  exp_t sb_q[$];

  function automatic ctl_t mk(input logic [3:0] st, input logic err, input logic req,
                              input logic io, input logic mr, input logic mw,
                              input logic irw, input logic pcw, input logic pcwc,
                              input logic [1:0] pcs, input logic rw, input logic [1:0] m2r,
                              input logic [1:0] sa, input logic [1:0] sbb,
                              input logic [1:0] op);
    return {st, err, req, io, mr, mw, irw, pcw, pcwc, pcs, rw, m2r, sa, sbb, op};
  endfunction

  // Expected control values for each state, taken from the state table.
  function automatic ctl_t expect_ctl(input int st, input logic rdy);
    case (st)
      0:  return mk(4'd0,  0, 1, 0, 1, 0, rdy, rdy, 0, 2'd0, 0, 2'd0, 2'd0, 2'd1, 2'b00);
      1:  return mk(4'd1,  0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 2'd2, 2'd2, 2'b00);
      2:  return mk(4'd2,  0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 2'd1, 2'd2, 2'b00);
      3:  return mk(4'd3,  0, 1, 1, 1, 0, 0, 0, 0, 2'd0, 0, 2'd0, 2'd0, 2'd0, 2'b00);
      4:  return mk(4'd4,  0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 1, 2'd1, 2'd0, 2'd0, 2'b00);
      5:  return mk(4'd5,  0, 1, 1, 0, 1, 0, 0, 0, 2'd0, 0, 2'd0, 2'd0, 2'd0, 2'b00);
      6:  return mk(4'd6,  0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 2'd1, 2'd0, 2'b10);
      7:  return mk(4'd7,  0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 2'd1, 2'd2, 2'b11);
      8:  return mk(4'd8,  0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 1, 2'd0, 2'd0, 2'd0, 2'b00);
      9:  return mk(4'd9,  0, 0, 0, 0, 0, 0, 0, 1, 2'd1, 0, 2'd0, 2'd1, 2'd0, 2'b01);
      10: return mk(4'd10, 0, 0, 0, 0, 0, 0, 1, 0, 2'd1, 1, 2'd2, 2'd0, 2'd0, 2'b00);
      11: return mk(4'd11, 0, 0, 0, 0, 0, 0, 1, 0, 2'd2, 1, 2'd2, 2'd1, 2'd2, 2'b00);
      15: return mk(4'd15, 1, 0, 0, 0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 2'd0, 2'd0, 2'b00);
      default: return '0; // used while reset is asserted: everything low
    endcase
  endfunction

  // One cycle: drive the inputs, queue the expectation, then advance past the edge.
  // A negative expected state means reset is held, so all outputs are expected low.
  task automatic step(input string name, input logic rn, input logic [6:0] op,
                      input logic rdy, input int exp_st);
    exp_t e;
    rst_n  = rn;
    opcode = op;
    ready  = rdy;
    e.name = name;
    e.exp  = (exp_st < 0) ? '0 : expect_ctl(exp_st, rdy);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare the DUT outputs on the falling edge.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      ctl_t act;
      e   = sb_q.pop_front();
      act = {state, error, mem_req, iord, mem_read, mem_write, ir_write, pc_write,
             pc_wcond, pc_src, reg_write, mem_to_reg, src_a, src_b, alu_op};
      checks++;
      if (act !== e.exp) begin
        failures++;
        $display("FAIL %s: got state=%0d ctl=%h, want state=%0d ctl=%h",
                 e.name, act[22:19], act, e.exp[22:19], e.exp);
      end else begin
        $display("ok   %s: state=%0d ctl=%h", e.name, act[22:19], act);
      end
    end
  end

  task automatic rtype(input string name);
    step({name, "_fetch"}, 1, OP_RTYPE, 1, 0);
    step({name, "_decode"}, 1, OP_RTYPE, 1, 1);
    step({name, "_exec_r"}, 1, OP_RTYPE, 1, 6);
    step({name, "_aluwb"}, 1, OP_RTYPE, 1, 8);
  endtask

  initial begin
    rst_n  = 1'b0;
    opcode = '0;
    ready  = 1'b0;
    @(posedge clk);
    #1;
    step("reset0", 0, OP_RTYPE, 1, -1);
    step("reset1", 0, OP_RTYPE, 1, -1);

    // Three back-to-back R-type instructions (also used by the counter check).
    rtype("r0");
    rtype("r1");
    rtype("r2");
`ifdef CTRL_PERF_EN
    checks++;
    if (instret !== 32'd3) begin
      failures++;
      $display("FAIL perf_instret: got %0d want 3", instret);
    end
    checks++;
    if (cycles !== 32'd12) begin
      failures++;
      $display("FAIL perf_cycles: got %0d want 12", cycles);
    end
`endif

    // Load with three stall cycles in MEMRD.
    step("ld_fetch", 1, OP_LOAD, 1, 0);
    step("ld_decode", 1, OP_LOAD, 1, 1);
    step("ld_memadr", 1, OP_LOAD, 1, 2);
    for (int i = 0; i < 3; i++) step("ld_memrd_wait", 1, OP_LOAD, 0, 3);
    step("ld_memrd_rdy", 1, OP_LOAD, 1, 3);
    step("ld_memwb", 1, OP_LOAD, 1, 4);

    // Store, I-type, branch, jal and jalr with zero wait.
    step("st_fetch", 1, OP_STORE, 1, 0);
    step("st_decode", 1, OP_STORE, 1, 1);
    step("st_memadr", 1, OP_STORE, 1, 2);
    step("st_memwr", 1, OP_STORE, 1, 5);
    step("i_fetch", 1, OP_ITYPE, 1, 0);
    step("i_decode", 1, OP_ITYPE, 1, 1);
    step("i_exec_i", 1, OP_ITYPE, 1, 7);
    step("i_aluwb", 1, OP_ITYPE, 1, 8);
    step("br_fetch", 1, OP_BRANCH, 1, 0);
    step("br_decode", 1, OP_BRANCH, 1, 1);
    step("br_branch", 1, OP_BRANCH, 1, 9);
    step("jal_fetch", 1, OP_JAL, 1, 0);
    step("jal_decode", 1, OP_JAL, 1, 1);
    step("jal_jal", 1, OP_JAL, 1, 10);
    step("jalr_fetch", 1, OP_JALR, 1, 0);
    step("jalr_decode", 1, OP_JALR, 1, 1);
    step("jalr_jalr", 1, OP_JALR, 1, 11);

    // Ready on the limit cycle (16th FETCH cycle) wins over the timeout.
    for (int i = 0; i < 15; i++) step("lim_fetch_wait", 1, OP_RTYPE, 0, 0);
    step("lim_fetch_rdy", 1, OP_RTYPE, 1, 0);
    step("lim_decode", 1, OP_RTYPE, 1, 1);
    step("lim_exec_r", 1, OP_RTYPE, 1, 6);
    step("lim_aluwb", 1, OP_RTYPE, 1, 8);

    // Reset in the middle of a store access drops the request immediately.
    step("rm_fetch", 1, OP_STORE, 1, 0);
    step("rm_decode", 1, OP_STORE, 1, 1);
    step("rm_memadr", 1, OP_STORE, 1, 2);
    step("rm_reset", 0, OP_STORE, 1, -1);
    step("rm_fetch_after", 1, OP_RTYPE, 1, 0);
    step("rm_decode_after", 1, OP_RTYPE, 1, 1);
    step("rm_exec_r", 1, OP_RTYPE, 1, 6);
    step("rm_aluwb", 1, OP_RTYPE, 1, 8);

    // Illegal opcode traps to ERROR; reset clears it.
    step("bad_fetch", 1, OP_BAD, 1, 0);
    step("bad_decode", 1, OP_BAD, 1, 1);
    step("bad_error0", 1, OP_BAD, 1, 15);
    step("bad_error1", 1, OP_RTYPE, 1, 15);
    step("bad_reset", 0, OP_RTYPE, 1, -1);
    step("bad_fetch_after", 1, OP_RTYPE, 0, 0);

    // A FETCH stall times out after 16 cycles; the error is sticky.
    for (int i = 0; i < 15; i++) step("to_fetch_wait", 1, OP_RTYPE, 0, 0);
    step("to_error0", 1, OP_RTYPE, 0, 15);
    step("to_error1", 1, OP_RTYPE, 1, 15);
    step("to_error2", 1, OP_RTYPE, 1, 15);
    step("to_reset", 0, OP_RTYPE, 1, -1);
    step("to_fetch_after", 1, OP_RTYPE, 1, 0);

    // Let the monitor drain the remaining expectations.
    for (int i = 0; i < 4 && sb_q.size() > 0; i++) @(negedge clk);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
